// File: rtl/ym_bus_write_queue.sv
// ym_bus_write_queue: takes asynchronous host bus writes, queues them in a
// FIFO and replays each one to the core with a setup cycle, a fixed-length
// strobe and a minimum gap between strobes.
// Optional build macro YM_BUS_GLITCH_FILTER_EN: host writes must stay active
// for two consecutive synchronised cycles before they count.
module ym_bus_write_queue #(
  parameter int FIFO_DEPTH  = 8,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 64
) (
  input  logic                          hsclk,
  input  logic                          rst_n,
  input  logic                          cs_n,
  input  logic                          wr_n,
  input  logic                          a0,
  input  logic [7:0]                    din,
  input  logic                          core_busy,
  input  logic                          clr_ovf,
  output logic                          core_wr_n,
  output logic                          core_a0,
  output logic [7:0]                    core_din,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = 10;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit            GAP_SKIP  = (GAP_CYCLES == 0);
  localparam logic [AW:0]   FULL_LVL  = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;

  logic          cs_n_p0, cs_n_p1, wr_n_p0, wr_n_p1;
  logic          vld_p0, vld_p1;
  logic          host_raw, host_wr, armed, hw, hw_p2;
  logic [8:0]    cap_p2;
  logic          push, pop, full, push_ok, drop;
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          gap_done;

  // Stage p0/p1: two-flop synchronisers; vld marks when p1 holds a real sample
  always_ff @(posedge hsclk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n_p0 <= 1'b1;
      cs_n_p1 <= 1'b1;
      wr_n_p0 <= 1'b1;
      wr_n_p1 <= 1'b1;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      cs_n_p0 <= cs_n;
      cs_n_p1 <= cs_n_p0;
      wr_n_p0 <= wr_n;
      wr_n_p1 <= wr_n_p0;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
    end
  end

  assign host_raw = ~(cs_n_p1 | wr_n_p1);

`ifdef YM_BUS_GLITCH_FILTER_EN
  logic raw_p2;

  // Remember the previous synchronised sample so single-cycle pulses are rejected
  always_ff @(posedge hsclk or negedge rst_n) begin
    if (!rst_n) raw_p2 <= 1'b0;
    else        raw_p2 <= host_raw;
  end

  assign host_wr = host_raw & raw_p2;
`else
  assign host_wr = host_raw;
`endif

  // Arm only after a genuine idle sample so a write spanning reset release is ignored
  always_ff @(posedge hsclk or negedge rst_n) begin
    if (!rst_n)                armed <= 1'b0;
    else if (vld_p1 && !host_raw) armed <= 1'b1;
  end

  assign hw = host_wr & armed;

  // Stage p2: previous write-active state, used to find the end of a write
  always_ff @(posedge hsclk or negedge rst_n) begin
    if (!rst_n) hw_p2 <= 1'b0;
    else        hw_p2 <= hw;
  end

  // Stage p2: keep sampling address/data for as long as the write is active
  always_ff @(posedge hsclk) begin
    if (hw) cap_p2 <= {a0, din};
  end

  assign push    = hw_p2 & ~hw;
  assign full    = (level == FULL_LVL);
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;
  assign gap_done = GAP_SKIP || (cnt_q == GAP_LAST);

  // FIFO storage; a pop in the same cycle frees the slot that is rewritten
  always_ff @(posedge hsclk) begin
    if (push_ok) mem[wr_ptr] <= cap_p2;
  end

  // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge hsclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow; a new drop outranks a clear in the same cycle
  always_ff @(posedge hsclk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  // Output sequencer state register
  always_ff @(posedge hsclk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; pop happens on the IDLE->SETUP transition
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if ((level != '0) && !core_busy) begin
          pop     = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP:   state_d = STROBE;
      STROBE:  if (cnt_q == HOLD_LAST) state_d = GAP;
      GAP:     if (gap_done && !core_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Cycle counter for strobe length and gap; restarts on every state change
  always_ff @(posedge hsclk or negedge rst_n) begin
    if (!rst_n)                    cnt_q <= '0;
    else if (state_d != state_q)   cnt_q <= '0;
    else if ((state_q == STROBE) || ((state_q == GAP) && !gap_done))
                                   cnt_q <= cnt_q + 1'b1;
  end

  // Core-side outputs: strobe follows the STROBE state, data holds the last pop
  always_ff @(posedge hsclk or negedge rst_n) begin
    if (!rst_n) begin
      core_wr_n <= 1'b1;
      core_a0   <= 1'b0;
      core_din  <= '0;
    end else begin
      core_wr_n <= (state_d != STROBE);
      if (pop) {core_a0, core_din} <= mem[rd_ptr];
    end
  end

  // Registered busy summary for the host
  always_ff @(posedge hsclk or negedge rst_n) begin
    if (!rst_n) busy <= 1'b0;
    else        busy <= (level != '0) | (state_q != IDLE) | core_busy;
  end

endmodule

// File: tb/tb_ym_bus_write_queue.sv
// Testbench for ym_bus_write_queue with default parameters.
module tb_ym_bus_write_queue;
  localparam int DEPTH = 8;
  localparam int HOLD  = 8;
  localparam int GAP   = 64;

  logic       hsclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1, wr_n = 1'b1, a0 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       core_busy = 1'b0, clr_ovf = 1'b0;
  logic       core_wr_n, core_a0, busy, overflow;
  logic [7:0] core_din;
  logic [3:0] level;

  ym_bus_write_queue #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .hsclk(hsclk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n), .a0(a0), .din(din),
    .core_busy(core_busy), .clr_ovf(clr_ovf), .core_wr_n(core_wr_n), .core_a0(core_a0),
    .core_din(core_din), .busy(busy), .overflow(overflow), .level(level));

  always #5 hsclk = ~hsclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];

  typedef struct {
    logic       a0;
    logic [7:0] din;
    logic       exp_a0;
    logic [7:0] exp_din;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge hsclk);
    cyc++;
  end

  // Strobe monitor: records every core write, checks length, stability and spacing
  int n_strobes = 0, start_cyc = 0, end_cyc = 0, low_cnt = 0;
  logic in_s = 1'b0, have_end = 1'b0;
  logic [8:0] s_data;
  initial forever begin
    @(negedge hsclk);
    if (!rst_n) begin
      in_s = 1'b0;
      have_end = 1'b0;
    end else if (!in_s && core_wr_n === 1'b0) begin
      in_s = 1'b1;
      low_cnt = 1;
      s_data = {core_a0, core_din};
      obs_q.push_back(s_data);
      n_strobes++;
      start_cyc = cyc;
      if (have_end) chk("strobe_gap_ge_min", 32'((cyc - end_cyc) >= GAP), 1);
    end else if (in_s && core_wr_n === 1'b0) begin
      low_cnt++;
      chk("strobe_data_stable", {23'd0, core_a0, core_din}, {23'd0, s_data});
    end else if (in_s && core_wr_n === 1'b1) begin
      in_s = 1'b0;
      chk("strobe_len", low_cnt, HOLD);
      have_end = 1'b1;
      end_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge hsclk);
    #1;
  endtask

  task automatic host_write(input logic a, input logic [7:0] d, input int len, input bit lat);
    int l0;
    a0 = a; din = d; cs_n = 1'b0; wr_n = 1'b0;
    tick(len);
    l0 = int'(level);
    wr_n = 1'b1;
    tick(4);
    if (lat) chk("push_latency", level, l0 + 1);
    cs_n = 1'b1;
    tick(2);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (!(busy === 1'b0 && level === 4'd0) && n < max) begin
      tick(1);
      n++;
    end
    chk("drain_timeout", 32'(n < max), 1);
  endtask

  task automatic compare_q(input string name);
    int m;
    chk({name, "_count"}, obs_q.size(), exp_q.size());
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) chk(name, {23'd0, obs_q[i]}, {23'd0, exp_q[i]});
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int s0, s1, c0, n, w;
    logic a;
    logic [7:0] d;

    tbl[0] = '{1'b0, 8'h20, 1'b0, 8'h20};
    tbl[1] = '{1'b1, 8'hC7, 1'b1, 8'hC7};
    tbl[2] = '{1'b1, 8'hFF, 1'b1, 8'hFF};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 8'h00};

    // reset state
    tick(3);
    chk("rst_core_wr_n", core_wr_n, 1);
    chk("rst_core_a0", core_a0, 0);
    chk("rst_core_din", core_din, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(4);

    // table-driven writes replayed in order
    for (int i = 0; i < 4; i++) host_write(tbl[i].a0, tbl[i].din, 3, 1'b0);
    wait_idle(2000);
    chk("table_count", obs_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++)
      chk("table_vec", {23'd0, obs_q[i]}, {23'd0, tbl[i].exp_a0, tbl[i].exp_din});
    chk("hold_last_popped", {core_a0, core_din}, {tbl[3].exp_a0, tbl[3].exp_din});
    obs_q.delete();

    // burst of 10 writes with core held busy: 9 and 10 dropped
    core_busy = 1'b1;
    tick(2);
    for (int k = 0; k < 10; k++) begin
      host_write(k[0], 8'(8'h40 + k), 2, k == 0);
      if (k < DEPTH) exp_q.push_back({k[0], 8'(8'h40 + k)});
      if (k == DEPTH - 1) chk("ovf_not_yet_at_full", overflow, 0);
      if (k == DEPTH) chk("ovf_on_first_drop", overflow, 1);
    end
    chk("burst_level", level, DEPTH);
    chk("burst_overflow", overflow, 1);
    clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
    chk("ovf_cleared", overflow, 0);
    // clear pulse coinciding with a new drop: overflow must stay set
    a0 = 1'b1; din = 8'hEE; cs_n = 1'b0; wr_n = 1'b0;
    tick(3);
    wr_n = 1'b1;
    tick(2);
    clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
    chk("ovf_set_beats_clr", overflow, 1);
    chk("full_level_kept", level, DEPTH);
    cs_n = 1'b1;
    tick(3);
    clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
    chk("ovf_cleared_again", overflow, 0);
    core_busy = 1'b0;
    wait_idle(3000);
    compare_q("ovf_order");

    // core_busy held after a strobe delays the next one
    s0 = n_strobes;
    host_write(1'b0, 8'h11, 3, 1'b0);
    host_write(1'b1, 8'h22, 3, 1'b0);
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h22});
    n = 0;
    while (!(n_strobes == s0 + 1 && !in_s) && n < 300) begin tick(1); n++; end
    chk("first_strobe_timeout", 32'(n < 300), 1);
    core_busy = 1'b1;
    s1 = n_strobes;
    tick(200);
    chk("no_strobe_while_busy", n_strobes, s1);
    core_busy = 1'b0;
    c0 = cyc;
    n = 0;
    while (n_strobes == s1 && n < 100) begin tick(1); n++; end
    chk("strobe_after_busy_timeout", 32'(n < 100), 1);
    chk("setup_after_busy_falls", 32'(start_cyc >= c0 + 2), 1);
    wait_idle(1000);
    compare_q("busy_hold");

    // one-cycle host write pulse
    core_busy = 1'b1;
    a0 = 1'b1; din = 8'h3C; cs_n = 1'b0; wr_n = 1'b0;
    tick(1);
    cs_n = 1'b1; wr_n = 1'b1;
    tick(6);
`ifdef YM_BUS_GLITCH_FILTER_EN
    chk("glitch_level", level, 0);
`else
    chk("glitch_level", level, 1);
    exp_q.push_back({1'b1, 8'h3C});
`endif
    core_busy = 1'b0;
    wait_idle(1000);
    compare_q("glitch");

    // randomized batches against the queue model
    for (int b = 0; b < 3; b++) begin
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        core_busy = 1'($urandom);
        a = 1'($urandom);
        d = 8'($urandom);
        w = $urandom_range(2, 4);
        host_write(a, d, w, 1'b0);
        exp_q.push_back({a, d});
      end
      chk("random_no_overflow", overflow, 0);
      core_busy = 1'b0;
      wait_idle(4000);
      compare_q("random");
    end

    // reset in the middle of a strobe, then a write spanning reset release
    core_busy = 1'b1;
    host_write(1'b0, 8'h5A, 3, 1'b0);
    host_write(1'b1, 8'hA5, 3, 1'b0);
    core_busy = 1'b0;
    n = 0;
    while (core_wr_n !== 1'b0 && n < 50) begin tick(1); n++; end
    chk("strobe_before_reset_timeout", 32'(n < 50), 1);
    tick(2);
    chk("level_before_reset", level, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_strobe_wr_n", core_wr_n, 1);
    chk("rst_mid_strobe_level", level, 0);
    chk("rst_mid_strobe_busy", busy, 0);
    obs_q.delete();
    exp_q.delete();
    a0 = 1'b1; din = 8'h77; cs_n = 1'b0; wr_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    wr_n = 1'b1;
    tick(4);
    cs_n = 1'b1;
    tick(4);
    chk("write_across_reset_ignored", level, 0);
    tick(100);
    chk("no_strobe_after_reset", obs_q.size(), 0);
    chk("idle_after_reset", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
